// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, limits and state encoding for the divider issue controller
package div_pkg;

    localparam int DATA_W     = 24;
    localparam int MAX_CYCLES = 40;

    localparam logic [DATA_W-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        DBZ  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// rtl/div_issue_ctrl_if.sv - start/annul/ready handshake and operand/result bus to the divider
interface div_issue_ctrl_if
    import div_pkg::*;
#(
    parameter int DW = DATA_W
);

    logic          start;
    logic          annul;
    logic          signed_div;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic          ready;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;

    modport master (
        output start, annul, signed_div, op1, op2,
        input  ready, quotient, remainder
    );

    modport slave (
        input  start, annul, signed_div, op1, op2,
        output ready, quotient, remainder
    );

endinterface

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EX-stage initiator for the multi-cycle divider: issue, stall, capture, flush/timeout abort
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int DW     = DATA_W,
    parameter int MAXCYC = MAX_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_div_req_i,
    input  logic             ex_signed_i,
    input  logic [DW-1:0]    ex_op1_i,
    input  logic [DW-1:0]    ex_op2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             res_valid_o,
    output logic [DW-1:0]    quotient_o,
    output logic [DW-1:0]    remainder_o,
    output logic             dbz_o,
    output logic             timeout_o,
    div_issue_ctrl_if.master div
);

    localparam int CNT_W = (MAXCYC > 1) ? $clog2(MAXCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAXCYC - 1);

    div_state_e    state_q, state_d;
    logic          start_q, start_d;
    logic          annul_q, annul_d;
    logic          timeout_q, timeout_d;
    logic          signed_q, signed_d;
    logic [DW-1:0] op1_q, op1_d;
    logic [DW-1:0] op2_q, op2_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            annul_q   <= 1'b0;
            timeout_q <= 1'b0;
            signed_q  <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            hold_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            annul_q   <= annul_d;
            timeout_q <= timeout_d;
            signed_q  <= signed_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        annul_d     = 1'b0;
        timeout_d   = 1'b0;
        signed_d    = signed_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dbz_d       = dbz_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        stall_o     = 1'b0;
        res_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                stall_o = ex_div_req_i & ~flush_i;
                // A divider still showing ready has not returned to idle; wait for it.
                if (ex_div_req_i && !flush_i && !div.ready) begin
                    if (ex_op2_i == '0) begin
                        hold_d  = ex_op1_i;
                        state_d = DBZ;
                    end else begin
                        signed_d = ex_signed_i;
                        op1_d    = ex_op1_i;
                        op2_d    = ex_op2_i;
                        start_d  = 1'b1;
                        cnt_d    = '0;
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_o = ~flush_i;
                if (flush_i) begin
                    annul_d = 1'b1;
                    start_d = 1'b0;
                    state_d = IDLE;
                end else if (div.ready) begin
                    quot_d  = div.quotient;
                    rem_d   = div.remainder;
                    dbz_d   = 1'b0;
                    start_d = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    annul_d   = 1'b1;
                    timeout_d = 1'b1;
                    start_d   = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DBZ: begin
                stall_o = ~flush_i;
                quot_d  = DW'(DBZ_QUOTIENT);
                rem_d   = hold_q;
                dbz_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                res_valid_o = ~flush_i;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The state register clears asynchronously, but the IDLE stall term still follows the request.
        if (rst) begin
            stall_o     = 1'b0;
            res_valid_o = 1'b0;
        end
    end

    assign div.start      = start_q;
    assign div.annul      = annul_q;
    assign div.signed_div = signed_q;
    assign div.op1        = op1_q;
    assign div.op2        = op2_q;

    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
    assign dbz_o       = dbz_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - scoreboard bench for div_issue_ctrl with a behavioural divider
module tb_div_issue_ctrl;
    import div_pkg::*;

    localparam int W = 24;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         ex_div_req_i, ex_signed_i, flush_i;
    logic [W-1:0] ex_op1_i, ex_op2_i;
    logic         stall_o, res_valid_o, dbz_o, timeout_o;
    logic [W-1:0] quotient_o, remainder_o;

    div_issue_ctrl_if #(.DW(W)) dif ();

    div_issue_ctrl #(.DW(W), .MAXCYC(40)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_div_req_i(ex_div_req_i),
        .ex_signed_i (ex_signed_i),
        .ex_op1_i    (ex_op1_i),
        .ex_op2_i    (ex_op2_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .res_valid_o (res_valid_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .dbz_o       (dbz_o),
        .timeout_o   (timeout_o),
        .div         (dif)
    );

    int n_vec  = 0;
    int n_miss = 0;
    exp_t sb[$];

    // Behavioural divider: ready pulses for one cycle lat+1 cycles after it sees start.
    int           lat;
    logic         force_rdy;
    logic         m_busy, m_rdy;
    int           m_cnt;
    logic [W-1:0] m_q, m_r;

    function automatic logic [W-1:0] sdiv(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        return a / b;
    endfunction

    function automatic logic [W-1:0] srem(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        return a % b;
    endfunction

    assign dif.ready     = m_rdy | force_rdy;
    assign dif.quotient  = m_q;
    assign dif.remainder = m_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_cnt  <= 0;
            m_q    <= '0;
            m_r    <= '0;
        end else begin
            m_rdy <= 1'b0;
            if (dif.annul) begin
                m_busy <= 1'b0;
            end else if (!m_busy && !m_rdy && dif.start) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                if (dif.signed_div) begin
                    m_q <= sdiv(dif.op1, dif.op2);
                    m_r <= srem(dif.op1, dif.op2);
                end else begin
                    m_q <= dif.op1 / dif.op2;
                    m_r <= dif.op1 % dif.op2;
                end
            end else if (m_busy) begin
                if (m_cnt == lat) begin
                    m_rdy  <= 1'b1;
                    m_busy <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid_o) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_result: q=0x%0h r=0x%0h dbz=%0b with nothing expected",
                         quotient_o, remainder_o, dbz_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (quotient_o !== e.q || remainder_o !== e.r || dbz_o !== e.dbz) begin
                    n_miss++;
                    $display("FAIL result: got q=0x%0h r=0x%0h dbz=%0b expected q=0x%0h r=0x%0h dbz=%0b",
                             quotient_o, remainder_o, dbz_o, e.q, e.r, e.dbz);
                end
            end
        end
    end

    task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                           input int exp_lat);
        int n;
        int held_bad;
        bit got;
        bit start_seen;
        exp_t e;
        e.q = eq; e.r = er; e.dbz = edbz;
        sb.push_back(e);
        @(negedge clk);
        ex_div_req_i = 1'b1; ex_signed_i = sgn; ex_op1_i = a; ex_op2_i = b;
        n = 0; got = 0; held_bad = 0; start_seen = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (dif.start) start_seen = 1;
            if (res_valid_o) got = 1;
            else if (stall_o && start_seen &&
                     !(dif.start && dif.signed_div == sgn && dif.op1 == a && dif.op2 == b))
                held_bad++;
        end
        chk("res_seen", 32'(got), 32'd1);
        chk("latency", n, exp_lat);
        chk("stall_in_done", 32'(stall_o), 32'd0);
        chk("start_used", 32'(start_seen), edbz ? 32'd0 : 32'd1);
        chk("start_held", held_bad, 0);
        ex_div_req_i = 1'b0;
        @(negedge clk);
        chk("res_valid_one_cycle", 32'(res_valid_o), 32'd0);
    endtask

    initial begin
        int n;
        bit seen;
        rst = 1'b1; lat = 26; force_rdy = 1'b0; flush_i = 1'b0;
        ex_div_req_i = 1'b1; ex_signed_i = 1'b0; ex_op1_i = '0; ex_op2_i = 24'd3;

        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_res_valid", 32'(res_valid_o), 32'd0);
        chk("rst_start", 32'(dif.start), 32'd0);
        chk("rst_q", 32'(quotient_o), 32'd0);
        chk("rst_r", 32'(remainder_o), 32'd0);
        chk("rst_dbz_timeout_annul", {29'd0, dbz_o, timeout_o, dif.annul}, 32'd0);
        ex_div_req_i = 1'b0;
        rst = 1'b0;

        run_div(1'b0, 24'd704, 24'd36, 24'h000013, 24'h000014, 1'b0, 29);
        run_div(1'b1, 24'hFFFF9C, 24'h000007, 24'hFFFFF2, 24'hFFFFFE, 1'b0, 29);
        run_div(1'b0, 24'd5, 24'd0, 24'hFFFFFF, 24'h000005, 1'b1, 2);

        // Flush on the third BUSY cycle
        @(negedge clk);
        ex_div_req_i = 1'b1; ex_signed_i = 1'b0; ex_op1_i = 24'd704; ex_op2_i = 24'd36;
        repeat (3) @(negedge clk);
        flush_i = 1'b1; ex_div_req_i = 1'b0;
        #1 chk("flush_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_annul", 32'(dif.annul), 32'd1);
        chk("flush_start_low", 32'(dif.start), 32'd0);
        @(negedge clk);
        chk("flush_annul_once", 32'(dif.annul), 32'd0);
        repeat (3) @(negedge clk);
        run_div(1'b0, 24'd1000, 24'd7, 24'h00008E, 24'h000006, 1'b0, 29);

        // Guard: divider still showing ready blocks issue but stalls
        force_rdy = 1'b1;
        @(negedge clk);
        ex_div_req_i = 1'b1; ex_op1_i = 24'd10; ex_op2_i = 24'd2;
        repeat (2) @(negedge clk);
        chk("guard_stall", 32'(stall_o), 32'd1);
        chk("guard_no_start", 32'(dif.start), 32'd0);
        ex_div_req_i = 1'b0; force_rdy = 1'b0;
        @(negedge clk);

        // Timeout: divider never answers
        lat = 1000;
        @(negedge clk);
        ex_div_req_i = 1'b1; ex_signed_i = 1'b0; ex_op1_i = 24'd50; ex_op2_i = 24'd5;
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (timeout_o) seen = 1;
        end
        ex_div_req_i = 1'b0;
        chk("timeout_seen", 32'(seen), 32'd1);
        chk("timeout_cycle", n, 41);
        chk("timeout_annul", 32'(dif.annul), 32'd1);
        chk("timeout_start_low", 32'(dif.start), 32'd0);
        @(negedge clk);
        chk("timeout_pulse", {30'd0, timeout_o, dif.annul}, 32'd0);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-BUSY
        lat = 26;
        @(negedge clk);
        ex_div_req_i = 1'b1; ex_op1_i = 24'd704; ex_op2_i = 24'd36;
        repeat (5) @(negedge clk);
        chk("pre_rst_start", 32'(dif.start), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_start", 32'(dif.start), 32'd0);
        chk("arst_stall", 32'(stall_o), 32'd0);
        chk("arst_annul", 32'(dif.annul), 32'd0);
        chk("arst_outputs", {quotient_o[7:0], remainder_o[7:0], 5'd0, dbz_o, timeout_o, res_valid_o}, 32'd0);
        @(negedge clk);
        ex_div_req_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_state_idle", 32'(dut.state_q), 32'(IDLE));

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
